// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: request kind and ID-table entry.
package mem_arbiter_pkg;

    localparam int unsigned MAX_REQ = 2;
    localparam int unsigned OWNER_W = (MAX_REQ > 1) ? $clog2(MAX_REQ) : 1;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_type_e;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } arb_entry_t;

endpackage

// File: rtl/mem_arbiter_id.sv
// Transaction-ID pool: per-ID valid/owner table with lowest-free allocation.
module id_pool
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ID_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_en,
    input  logic [OWNER_W-1:0]  alloc_owner,
    output logic [ID_WIDTH-1:0] alloc_id,
    output logic                empty,
    input  logic                free_en,
    input  logic [ID_WIDTH-1:0] free_id,
    input  logic [ID_WIDTH-1:0] lookup_id,
    output arb_entry_t          lookup_entry
);

    localparam int unsigned N_ID = 2 ** ID_WIDTH;

    arb_entry_t entries_q [N_ID];

    // Scan downward so the lowest free index is the last one written.
    always_comb begin
        alloc_id = '0;
        empty    = 1'b1;
        for (int unsigned i = N_ID; i > 0; i--) begin
            if (!entries_q[ID_WIDTH'(i - 1)].valid) begin
                alloc_id = ID_WIDTH'(i - 1);
                empty    = 1'b0;
            end
        end
    end

    assign lookup_entry = entries_q[lookup_id];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ID; i++) begin
                entries_q[ID_WIDTH'(i)] <= '0;
            end
        end else begin
            if (alloc_en) begin
                entries_q[alloc_id].valid <= 1'b1;
                entries_q[alloc_id].owner <= alloc_owner;
            end
            if (free_en) begin
                entries_q[free_id].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between cache clients,
// with ID-tagged loads whose responses are routed back to the owning client.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ      = MAX_REQ,
    parameter int unsigned PA_WIDTH   = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            i_cli_enable,
    input  logic [N_REQ-1:0]            i_cli_type,
    input  logic [N_REQ*PA_WIDTH-1:0]   i_cli_addr,
    input  logic [N_REQ*LINE_WIDTH-1:0] i_cli_data,
    output logic [N_REQ-1:0]            o_cli_ack,
    output logic [ID_WIDTH-1:0]         o_cli_ack_id,
    output logic [N_REQ-1:0]            o_cli_resp_enable,
    output logic [LINE_WIDTH-1:0]       o_cli_resp_data,
    output logic [ID_WIDTH-1:0]         o_cli_id_response,
    input  logic [N_REQ-1:0]            i_cli_resp_ack,
    output logic                        o_mem_enable,
    output logic                        o_mem_type,
    output logic [PA_WIDTH-1:0]         o_mem_addr,
    output logic [LINE_WIDTH-1:0]       o_mem_data,
    output logic [ID_WIDTH-1:0]         o_mem_id,
    input  logic                        i_mem_ready,
    input  logic                        i_mem_enable,
    input  logic [LINE_WIDTH-1:0]       i_mem_data,
    input  logic [ID_WIDTH-1:0]         i_mem_id,
    output logic                        o_mem_ack,
    output logic                        o_err_stray
);

    // Request slot and grant state
    logic                  slot_valid_q;
    mem_type_e             slot_type_q;
    logic [PA_WIDTH-1:0]   slot_addr_q;
    logic [LINE_WIDTH-1:0] slot_data_q;
    logic [ID_WIDTH-1:0]   slot_id_q;
    logic [N_REQ-1:0]      ack_q;
    logic [ID_WIDTH-1:0]   ack_id_q;
    logic [OWNER_W-1:0]    last_q;

    // Response register
    logic                  resp_valid_q;
    logic [OWNER_W-1:0]    resp_owner_q;
    logic [LINE_WIDTH-1:0] resp_data_q;
    logic [ID_WIDTH-1:0]   resp_id_q;
    logic                  stray_q;

    logic [N_REQ-1:0]      eligible;
    logic                  grant_valid;
    logic [OWNER_W-1:0]    grant_idx;
    logic                  grant_fire;
    logic                  slot_free;
    mem_type_e             grant_type;
    logic [PA_WIDTH-1:0]   grant_addr;
    logic [LINE_WIDTH-1:0] grant_data;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [N_REQ-1:0]      grant_onehot;

    logic                  pool_empty;
    logic [ID_WIDTH-1:0]   pool_alloc_id;
    logic                  alloc_en;
    arb_entry_t            lookup_entry;
    logic                  resp_capture;
    logic                  resp_hit;
    logic                  resp_consumed;

    id_pool #(
        .ID_WIDTH (ID_WIDTH)
    ) u_id_pool (
        .clk          (clk),
        .rst          (rst),
        .alloc_en     (alloc_en),
        .alloc_owner  (grant_idx),
        .alloc_id     (pool_alloc_id),
        .empty        (pool_empty),
        .free_en      (resp_hit),
        .free_id      (i_mem_id),
        .lookup_id    (i_mem_id),
        .lookup_entry (lookup_entry)
    );

    assign slot_free = !slot_valid_q || i_mem_ready;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = i_cli_enable[i] && !ack_q[i] &&
                          (i_cli_type[i] == MEM_STORE || !pool_empty);
        end
    end

    // Walk candidates farthest-first so the one right after last_q wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned off = N_REQ; off >= 1; off--) begin
            if (eligible[OWNER_W'((32'(last_q) + off) % N_REQ)]) begin
                grant_valid = 1'b1;
                grant_idx   = OWNER_W'((32'(last_q) + off) % N_REQ);
            end
        end
    end

    assign grant_fire   = grant_valid && slot_free;
    assign grant_type   = mem_type_e'(i_cli_type[grant_idx]);
    assign grant_addr   = i_cli_addr[32'(grant_idx) * PA_WIDTH +: PA_WIDTH];
    assign grant_data   = i_cli_data[32'(grant_idx) * LINE_WIDTH +: LINE_WIDTH];
    assign grant_id     = (grant_type == MEM_LOAD) ? pool_alloc_id : '0;
    assign grant_onehot = N_REQ'(1) << grant_idx;
    assign alloc_en     = grant_fire && (grant_type == MEM_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid_q <= 1'b0;
            slot_type_q  <= MEM_LOAD;
            slot_addr_q  <= '0;
            slot_data_q  <= '0;
            slot_id_q    <= '0;
            ack_q        <= '0;
            ack_id_q     <= '0;
            last_q       <= OWNER_W'(N_REQ - 1);
        end else begin
            if (grant_fire) begin
                slot_valid_q <= 1'b1;
                slot_type_q  <= grant_type;
                slot_addr_q  <= grant_addr;
                slot_data_q  <= grant_data;
                slot_id_q    <= grant_id;
                ack_q        <= grant_onehot;
                ack_id_q     <= grant_id;
                last_q       <= grant_idx;
            end else begin
                ack_q    <= '0;
                ack_id_q <= '0;
                if (i_mem_ready) begin
                    slot_valid_q <= 1'b0;
                end
            end
        end
    end

    assign o_mem_ack     = !resp_valid_q || i_cli_resp_ack[resp_owner_q];
    assign resp_capture  = i_mem_enable && o_mem_ack;
    assign resp_hit      = resp_capture && lookup_entry.valid;
    assign resp_consumed = resp_valid_q && i_cli_resp_ack[resp_owner_q];

    // A stray response is still acked; it just never reaches a client.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            stray_q      <= 1'b0;
        end else begin
            if (resp_hit) begin
                resp_valid_q <= 1'b1;
                resp_owner_q <= lookup_entry.owner;
                resp_data_q  <= i_mem_data;
                resp_id_q    <= i_mem_id;
            end else if (resp_consumed) begin
                resp_valid_q <= 1'b0;
            end
            if (resp_capture && !lookup_entry.valid) begin
                stray_q <= 1'b1;
            end
        end
    end

    always_comb begin
        o_cli_resp_enable = '0;
        if (resp_valid_q) begin
            o_cli_resp_enable[resp_owner_q] = 1'b1;
        end
    end

    assign o_cli_resp_data   = resp_data_q;
    assign o_cli_id_response = resp_id_q;
    assign o_cli_ack         = ack_q;
    assign o_cli_ack_id      = ack_id_q;
    assign o_mem_enable      = slot_valid_q;
    assign o_mem_type        = slot_type_q;
    assign o_mem_addr        = slot_addr_q;
    assign o_mem_data        = slot_data_q;
    assign o_mem_id          = slot_id_q;
    assign o_err_stray       = stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (2 clients, 16 IDs).
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic [1:0]   cli_en;
    logic [1:0]   cli_type;
    logic [63:0]  cli_addr;
    logic [255:0] cli_data;
    logic [1:0]   ack;
    logic [3:0]   ack_id;
    logic [1:0]   resp_en;
    logic [127:0] resp_data;
    logic [3:0]   id_resp;
    logic [1:0]   cli_resp_ack;
    logic         mem_en;
    logic         mem_type;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data;
    logic [3:0]   mem_id;
    logic         mem_ready;
    logic         mem_resp_en;
    logic [127:0] mem_resp_data;
    logic [3:0]   mem_resp_id;
    logic         mem_ack;
    logic         err_stray;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(
        .N_REQ      (2),
        .PA_WIDTH   (32),
        .LINE_WIDTH (128),
        .ID_WIDTH   (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_cli_enable      (cli_en),
        .i_cli_type        (cli_type),
        .i_cli_addr        (cli_addr),
        .i_cli_data        (cli_data),
        .o_cli_ack         (ack),
        .o_cli_ack_id      (ack_id),
        .o_cli_resp_enable (resp_en),
        .o_cli_resp_data   (resp_data),
        .o_cli_id_response (id_resp),
        .i_cli_resp_ack    (cli_resp_ack),
        .o_mem_enable      (mem_en),
        .o_mem_type        (mem_type),
        .o_mem_addr        (mem_addr),
        .o_mem_data        (mem_data),
        .o_mem_id          (mem_id),
        .i_mem_ready       (mem_ready),
        .i_mem_enable      (mem_resp_en),
        .i_mem_data        (mem_resp_data),
        .i_mem_id          (mem_resp_id),
        .o_mem_ack         (mem_ack),
        .o_err_stray       (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cli_en        = '0;
        cli_type      = '0;
        cli_addr      = '0;
        cli_data      = '0;
        cli_resp_ack  = '0;
        mem_ready     = 1'b1;
        mem_resp_en   = 1'b0;
        mem_resp_data = '0;
        mem_resp_id   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic set_req(input int c, input logic t, input logic [31:0] a, input logic [127:0] d);
        cli_en[c]              = 1'b1;
        cli_type[c]            = t;
        cli_addr[c*32 +: 32]   = a;
        cli_data[c*128 +: 128] = d;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got=%b exp=0", mem_en); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_ack got=%b exp=00", ack); end
        checks++; if (resp_en !== 2'b00) begin errors++; $display("FAIL rst_resp_en got=%b exp=00", resp_en); end
        checks++; if (err_stray !== 1'b0) begin errors++; $display("FAIL rst_stray got=%b exp=0", err_stray); end
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL rst_mem_ack got=%b exp=1", mem_ack); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        set_req(1, 1'b0, 32'h100, '0);
        tick();
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL t1_ack got=%b exp=10", ack); end
        checks++; if (ack_id !== 4'd0) begin errors++; $display("FAIL t1_ack_id got=%0d exp=0", ack_id); end
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_type !== 1'b0 || mem_id !== 4'd0)
            begin errors++; $display("FAIL t1_mem got en=%b addr=%h type=%b id=%0d exp en=1 addr=100 type=0 id=0", mem_en, mem_addr, mem_type, mem_id); end
        cli_en = '0;
        tick();
        checks++; if (mem_en !== 1'b0 || ack !== 2'b00) begin errors++; $display("FAIL t1_drain got en=%b ack=%b exp en=0 ack=00", mem_en, ack); end
        repeat (3) tick();
        mem_resp_en = 1'b1; mem_resp_id = 4'd0; mem_resp_data = 128'hDEADBEEF;
        #1;
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL t1_mem_ack got=%b exp=1", mem_ack); end
        tick();
        mem_resp_en = 1'b0;
        checks++; if (resp_en !== 2'b10) begin errors++; $display("FAIL t1_resp_en got=%b exp=10", resp_en); end
        checks++; if (resp_data !== 128'hDEADBEEF) begin errors++; $display("FAIL t1_resp_data got=%h exp=deadbeef", resp_data); end
        checks++; if (id_resp !== 4'd0) begin errors++; $display("FAIL t1_resp_id got=%0d exp=0", id_resp); end
        cli_resp_ack = 2'b10;
        tick();
        cli_resp_ack = 2'b00;
        checks++; if (resp_en !== 2'b00) begin errors++; $display("FAIL t1_resp_clear got=%b exp=00", resp_en); end
    endtask

    // Continues from test_single_load: ID 0 must be free again and client 1 was last granted.
    task automatic test_contention();
        set_req(0, 1'b0, 32'h40, '0);
        set_req(1, 1'b1, 32'h80, 128'hCAFE_F00D);
        tick();
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL t2_first_ack got=%b exp=01", ack); end
        checks++; if (mem_addr !== 32'h40 || mem_type !== 1'b0 || mem_id !== 4'd0 || ack_id !== 4'd0)
            begin errors++; $display("FAIL t2_first_mem got addr=%h type=%b id=%0d ack_id=%0d exp addr=40 type=0 id=0 ack_id=0", mem_addr, mem_type, mem_id, ack_id); end
        tick();
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL t2_second_ack got=%b exp=10", ack); end
        checks++; if (mem_addr !== 32'h80 || mem_type !== 1'b1 || mem_data !== 128'hCAFE_F00D || ack_id !== 4'd0)
            begin errors++; $display("FAIL t2_second_mem got addr=%h type=%b data=%h ack_id=%0d exp addr=80 type=1 data=cafef00d ack_id=0", mem_addr, mem_type, mem_data, ack_id); end
        cli_en = '0;
        tick();
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL t2_no_regrant got=%b exp=00", ack); end
    endtask

    task automatic test_stall();
        do_reset();
        mem_ready = 1'b0;
        set_req(0, 1'b0, 32'h200, '0);
        set_req(1, 1'b0, 32'h300, '0);
        tick();
        checks++; if (ack !== 2'b01 || mem_addr !== 32'h200) begin errors++; $display("FAIL t3_grant got ack=%b addr=%h exp ack=01 addr=200", ack, mem_addr); end
        cli_en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h200 || mem_id !== 4'd0 || ack !== 2'b00)
                begin errors++; $display("FAIL t3_hold%0d got en=%b addr=%h id=%0d ack=%b exp en=1 addr=200 id=0 ack=00", k, mem_en, mem_addr, mem_id, ack); end
        end
        mem_ready = 1'b1;
        tick();
        checks++; if (ack !== 2'b10 || mem_addr !== 32'h300 || mem_id !== 4'd1 || ack_id !== 4'd1)
            begin errors++; $display("FAIL t3_release got ack=%b addr=%h id=%0d ack_id=%0d exp ack=10 addr=300 id=1 ack_id=1", ack, mem_addr, mem_id, ack_id); end
        cli_en = '0;
    endtask

    task automatic test_pool_full();
        do_reset();
        set_req(0, 1'b0, 32'h1000, '0);
        set_req(1, 1'b0, 32'h2000, '0);
        for (int k = 0; k < 16; k++) begin
            tick();
            checks++; if (ack !== ((k % 2 == 0) ? 2'b01 : 2'b10) || ack_id !== 4'(k))
                begin errors++; $display("FAIL t4_alloc%0d got ack=%b id=%0d exp id=%0d", k, ack, ack_id, k); end
        end
        tick();
        checks++; if (ack !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL t4_stall got ack=%b en=%b exp ack=00 en=0", ack, mem_en); end
        set_req(1, 1'b1, 32'h500, 128'h5);
        tick();
        checks++; if (ack !== 2'b10 || mem_type !== 1'b1 || ack_id !== 4'd0)
            begin errors++; $display("FAIL t4_store got ack=%b type=%b id=%0d exp ack=10 type=1 id=0", ack, mem_type, ack_id); end
        cli_en[1] = 1'b0;
        mem_resp_en = 1'b1; mem_resp_id = 4'd5; mem_resp_data = 128'h55;
        tick();
        mem_resp_en = 1'b0;
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL t4_same_edge_realloc got ack=%b exp=00", ack); end
        checks++; if (resp_en !== 2'b10 || id_resp !== 4'd5) begin errors++; $display("FAIL t4_resp got en=%b id=%0d exp en=10 id=5", resp_en, id_resp); end
        tick();
        checks++; if (ack !== 2'b01 || ack_id !== 4'd5) begin errors++; $display("FAIL t4_realloc got ack=%b id=%0d exp ack=01 id=5", ack, ack_id); end
        cli_en = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 1'b0, 32'h600, '0);
        set_req(1, 1'b0, 32'h680, '0);
        repeat (2) tick();
        cli_en = '0;
        mem_resp_en = 1'b1; mem_resp_id = 4'd0; mem_resp_data = 128'hAAAA;
        tick();
        mem_resp_id = 4'd1; mem_resp_data = 128'hBBBB;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (resp_en !== 2'b01 || resp_data !== 128'hAAAA || mem_ack !== 1'b0)
                begin errors++; $display("FAIL t5_hold%0d got en=%b data=%h mem_ack=%b exp en=01 data=aaaa mem_ack=0", k, resp_en, resp_data, mem_ack); end
            tick();
        end
        cli_resp_ack = 2'b01;
        #1;
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL t5_ack_pass got=%b exp=1", mem_ack); end
        tick();
        cli_resp_ack = 2'b00;
        mem_resp_en = 1'b0;
        checks++; if (resp_en !== 2'b10 || resp_data !== 128'hBBBB || id_resp !== 4'd1)
            begin errors++; $display("FAIL t5_second got en=%b data=%h id=%0d exp en=10 data=bbbb id=1", resp_en, resp_data, id_resp); end
        cli_resp_ack = 2'b10;
        tick();
        cli_resp_ack = 2'b00;
        checks++; if (resp_en !== 2'b00) begin errors++; $display("FAIL t5_clear got=%b exp=00", resp_en); end
    endtask

    task automatic test_stray_and_reset();
        mem_resp_en = 1'b1; mem_resp_id = 4'd9; mem_resp_data = 128'h9;
        #1;
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL t6_stray_ack got=%b exp=1", mem_ack); end
        tick();
        mem_resp_en = 1'b0;
        checks++; if (resp_en !== 2'b00 || err_stray !== 1'b1) begin errors++; $display("FAIL t6_stray got en=%b err=%b exp en=00 err=1", resp_en, err_stray); end
        tick();
        checks++; if (err_stray !== 1'b1) begin errors++; $display("FAIL t6_sticky got=%b exp=1", err_stray); end
        mem_ready = 1'b0;
        set_req(0, 1'b0, 32'h700, '0);
        tick();
        cli_en = '0;
        checks++; if (mem_en !== 1'b1 || ack !== 2'b01) begin errors++; $display("FAIL t6_inflight got en=%b ack=%b exp en=1 ack=01", mem_en, ack); end
        rst = 1'b0;
        #1;
        checks++; if (mem_en !== 1'b0 || ack !== 2'b00 || mem_addr !== 32'h0 || err_stray !== 1'b0 || resp_en !== 2'b00)
            begin errors++; $display("FAIL t6_async_rst got en=%b ack=%b addr=%h err=%b resp=%b exp all 0", mem_en, ack, mem_addr, err_stray, resp_en); end
        rst = 1'b1;
        mem_ready = 1'b1;
        mem_resp_en = 1'b1; mem_resp_id = 4'd0; mem_resp_data = 128'h77;
        tick();
        mem_resp_en = 1'b0;
        checks++; if (resp_en !== 2'b00 || err_stray !== 1'b1) begin errors++; $display("FAIL t6_late_resp got en=%b err=%b exp en=00 err=1", resp_en, err_stray); end
        set_req(1, 1'b0, 32'h800, '0);
        tick();
        cli_en = '0;
        checks++; if (ack !== 2'b10 || ack_id !== 4'd0) begin errors++; $display("FAIL t6_pool_clear got ack=%b id=%0d exp ack=10 id=0", ack, ack_id); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_stall();
        test_pool_full();
        test_backpressure();
        test_stray_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
